// File: rtl/hsv_centroid_tracker_if.sv
// Pixel stream, threshold window and result bus of the HSV centroid tracker.
// The master drives pixels and thresholds; the slave (tracker) returns mask and centroid results.
interface hsv_centroid_tracker_if;
    logic        pixel_valid;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        frame_end;
    logic [7:0]  h, s, v;
    logic [7:0]  h1_min, h1_max, h2_min, h2_max;
    logic [7:0]  s_min, s_max, v_min, v_max;
    logic        enable;
    logic        mask;
    logic [10:0] centroid_x;
    logic [9:0]  centroid_y;
    logic [19:0] pixel_count;
    logic        found;
    logic        centroid_valid;
    logic        busy;
    logic        overrun;

    modport master (
        output pixel_valid, hcount, vcount, frame_end, h, s, v,
               h1_min, h1_max, h2_min, h2_max, s_min, s_max, v_min, v_max, enable,
        input  mask, centroid_x, centroid_y, pixel_count, found, centroid_valid, busy, overrun
    );

    modport slave (
        input  pixel_valid, hcount, vcount, frame_end, h, s, v,
               h1_min, h1_max, h2_min, h2_max, s_min, s_max, v_min, v_max, enable,
        output mask, centroid_x, centroid_y, pixel_count, found, centroid_valid, busy, overrun
    );
endinterface

// File: rtl/hsv_centroid_tracker.sv
// HSV threshold mask, per-frame coordinate accumulation and a serial restoring
// divider that turns the frame totals into the masked object's centroid.
module hsv_centroid_tracker #(
    parameter int MIN_PIXELS = 16,
    parameter int DIV_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    hsv_centroid_tracker_if.slave bus
);
    localparam int CNT_W  = 20;
    localparam int STEP_W = $clog2(DIV_W);

    typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;

    state_t            state, state_nxt;
    logic              hue_hit, in_range;
    logic [DIV_W-1:0]  sum_x, sum_y, tot_x, tot_y;
    logic [CNT_W-1:0]  count, tot_cnt;
    logic [DIV_W-1:0]  dvd_x, dvd_y, dvd_cur, dvd_nxt;
    logic [CNT_W-1:0]  dsr, rem, rem_nxt;
    logic [STEP_W-1:0] step;
    logic              last_step, busy;
    logic              mask_r, found_r, valid_r;
    logic [10:0]       cx_r;
    logic [9:0]        cy_r;
    logic [CNT_W-1:0]  pc_r;

    // One restoring step: shift the dividend MSB into the remainder, subtract when it fits.
    function automatic logic [CNT_W+DIV_W-1:0] div_step(
        input logic [CNT_W-1:0] r,
        input logic [DIV_W-1:0] d,
        input logic [CNT_W-1:0] dv
    );
        logic [CNT_W:0] trial;
        logic           q;
        trial = {r, d[DIV_W-1]};
        q     = (trial >= {1'b0, dv});
        if (q) trial = trial - {1'b0, dv};
        return {trial[CNT_W-1:0], d[DIV_W-2:0], q};
    endfunction

    always_comb begin
        hue_hit  = ((bus.h >= bus.h1_min) && (bus.h <= bus.h1_max)) ||
                   ((bus.h >= bus.h2_min) && (bus.h <= bus.h2_max));
        in_range = bus.enable && bus.pixel_valid && hue_hit &&
                   (bus.s >= bus.s_min) && (bus.s <= bus.s_max) &&
                   (bus.v >= bus.v_min) && (bus.v <= bus.v_max);
        // Totals include the pixel of the current cycle so a frame_end pixel is counted.
        tot_x    = sum_x + (in_range ? DIV_W'(bus.hcount) : '0);
        tot_y    = sum_y + (in_range ? DIV_W'(bus.vcount) : '0);
        tot_cnt  = count + CNT_W'(in_range);
    end

    always_comb begin
        dvd_cur            = (state == DIV_Y) ? dvd_y : dvd_x;
        {rem_nxt, dvd_nxt} = div_step(rem, dvd_cur, dsr);
        last_step          = (step == STEP_W'(DIV_W - 1));
        busy               = (state == DIV_X) || (state == DIV_Y);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.frame_end)
                         state_nxt = (tot_cnt >= CNT_W'(MIN_PIXELS)) ? DIV_X : DONE;
            DIV_X:   if (last_step) state_nxt = DIV_Y;
            DIV_Y:   if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            sum_x   <= '0;
            sum_y   <= '0;
            count   <= '0;
            dvd_x   <= '0;
            dvd_y   <= '0;
            dsr     <= '0;
            rem     <= '0;
            step    <= '0;
            mask_r  <= 1'b0;
            found_r <= 1'b0;
            valid_r <= 1'b0;
            cx_r    <= '0;
            cy_r    <= '0;
            pc_r    <= '0;
        end else begin
            state   <= state_nxt;
            mask_r  <= in_range;
            valid_r <= 1'b0;
            if (bus.frame_end) begin
                sum_x <= '0;
                sum_y <= '0;
                count <= '0;
            end else begin
                sum_x <= tot_x;
                sum_y <= tot_y;
                count <= tot_cnt;
            end
            case (state)
                IDLE: if (bus.frame_end) begin
                    dvd_x <= tot_x;
                    dvd_y <= tot_y;
                    dsr   <= tot_cnt;
                    rem   <= '0;
                    step  <= '0;
                    if (tot_cnt < CNT_W'(MIN_PIXELS)) begin
                        pc_r    <= tot_cnt;
                        found_r <= 1'b0;
                        valid_r <= 1'b1;
                    end
                end
                DIV_X, DIV_Y: begin
                    rem  <= last_step ? '0 : rem_nxt;
                    step <= last_step ? '0 : step + STEP_W'(1);
                    if (state == DIV_X) dvd_x <= dvd_nxt;
                    else                dvd_y <= dvd_nxt;
                    // Results are registered as DONE is entered so they are visible during DONE.
                    if (state == DIV_Y && last_step) begin
                        cx_r    <= dvd_x[10:0];
                        cy_r    <= dvd_nxt[9:0];
                        pc_r    <= dsr;
                        found_r <= 1'b1;
                        valid_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mask           = mask_r;
    assign bus.centroid_x     = cx_r;
    assign bus.centroid_y     = cy_r;
    assign bus.pixel_count    = pc_r;
    assign bus.found          = found_r;
    assign bus.centroid_valid = valid_r;
    assign bus.busy           = busy;
    assign bus.overrun        = bus.frame_end && busy;
endmodule

// File: tb/tb_hsv_centroid_tracker.sv
// Self-checking bench for hsv_centroid_tracker: directed scenarios with literal
// expectations plus randomized frames checked every cycle against a frame-level model.
module tb_hsv_centroid_tracker;
    localparam int MIN_PIXELS = 16;
    localparam int DIV_W      = 32;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    hsv_centroid_tracker_if bus ();

    hsv_centroid_tracker #(.MIN_PIXELS(MIN_PIXELS), .DIV_W(DIV_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model, evaluated once per cycle at negedge ----------------
    longint acc_x = 0, acc_y = 0, acc_n = 0;
    bit     pend_valid = 0, pend_found = 0;
    longint pend_cycle = 0, pend_x = 0, pend_y = 0, pend_n = 0;
    bit     e_mask = 0, e_found = 0, e_busy = 0, e_valid = 0;
    longint e_cx = 0, e_cy = 0, e_pc = 0;
    longint cyc = 0;

    function automatic bit model_hit();
        bit hue;
        hue = (bus.h >= bus.h1_min && bus.h <= bus.h1_max) ||
              (bus.h >= bus.h2_min && bus.h <= bus.h2_max);
        return bus.enable && bus.pixel_valid && hue &&
               bus.s >= bus.s_min && bus.s <= bus.s_max &&
               bus.v >= bus.v_min && bus.v <= bus.v_max;
    endfunction

    initial begin
        bit     ir, accept;
        longint tx, ty, tn;
        forever begin
            @(negedge clk);
            if (!reset) begin
                acc_x = 0; acc_y = 0; acc_n = 0; pend_valid = 0;
                e_mask = 0; e_cx = 0; e_cy = 0; e_pc = 0; e_found = 0;
                e_busy = 0; e_valid = 0;
            end else begin
                e_busy  = pend_valid && pend_found && (cyc < pend_cycle);
                e_valid = pend_valid && (cyc == pend_cycle);
                if (e_valid) begin
                    e_pc    = pend_n;
                    e_found = pend_found;
                    if (pend_found) begin
                        e_cx = pend_x;
                        e_cy = pend_y;
                    end
                end
            end
            chk("mask", bus.mask, e_mask);
            chk("busy", bus.busy, e_busy);
            chk("centroid_valid", bus.centroid_valid, e_valid);
            chk("overrun", bus.overrun, reset && bus.frame_end && e_busy);
            chk("centroid_x", bus.centroid_x, e_cx);
            chk("centroid_y", bus.centroid_y, e_cy);
            chk("pixel_count", bus.pixel_count, e_pc);
            chk("found", bus.found, e_found);
            if (reset) begin
                ir = model_hit();
                tx = acc_x + (ir ? longint'(bus.hcount) : 0);
                ty = acc_y + (ir ? longint'(bus.vcount) : 0);
                tn = acc_n + (ir ? 1 : 0);
                accept = bus.frame_end && !pend_valid;
                if (e_valid) pend_valid = 0;
                if (accept) begin
                    pend_valid = 1;
                    pend_n     = tn;
                    pend_found = (tn >= MIN_PIXELS);
                    pend_cycle = cyc + (pend_found ? 2 * DIV_W + 1 : 1);
                    if (pend_found) begin
                        pend_x = (tx / tn) % 2048;
                        pend_y = (ty / tn) % 1024;
                    end
                end
                if (bus.frame_end) begin
                    acc_x = 0; acc_y = 0; acc_n = 0;
                end else begin
                    acc_x = tx; acc_y = ty; acc_n = tn;
                end
                e_mask = ir;
            end
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_thr(input int h1a, h1b, h2a, h2b, sa, sb, va, vb);
        bus.h1_min = 8'(h1a); bus.h1_max = 8'(h1b);
        bus.h2_min = 8'(h2a); bus.h2_max = 8'(h2b);
        bus.s_min  = 8'(sa);  bus.s_max  = 8'(sb);
        bus.v_min  = 8'(va);  bus.v_max  = 8'(vb);
    endtask

    task automatic pix(input int x, y, hh, ss, vv, input bit fe);
        bus.pixel_valid = 1'b1;
        bus.hcount = 11'(x); bus.vcount = 10'(y);
        bus.h = 8'(hh); bus.s = 8'(ss); bus.v = 8'(vv);
        bus.frame_end = fe;
        step();
        bus.pixel_valid = 1'b0;
        bus.frame_end   = 1'b0;
    endtask

    task automatic fe();
        bus.pixel_valid = 1'b0;
        bus.frame_end   = 1'b1;
        step();
        bus.frame_end   = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.centroid_valid) begin
                lat = i;
                break;
            end
        end
        chk({tag, " latency"}, lat, exp_lat);
    endtask

    task automatic block16(input int x0, y0);
        for (int yy = 0; yy < 4; yy++)
            for (int xx = 0; xx < 4; xx++)
                pix(x0 + xx, y0 + yy, 30, 200, 200, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got 0 expected 1 (simulation did not finish)");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        reset = 1'b1;
        bus.pixel_valid = 0; bus.frame_end = 0; bus.enable = 1;
        bus.hcount = 0; bus.vcount = 0; bus.h = 0; bus.s = 0; bus.v = 0;
        set_thr(20, 40, 255, 0, 50, 255, 50, 255);
        #1 reset = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();

        // Dual hue window mask
        set_thr(0, 10, 240, 255, 0, 255, 0, 255);
        pix(5, 5, 250, 0, 0, 1'b0); @(negedge clk); chk("mask h=250", bus.mask, 1); step();
        pix(5, 5, 128, 0, 0, 1'b0); @(negedge clk); chk("mask h=128", bus.mask, 0); step();
        pix(5, 5, 10, 0, 0, 1'b0);  @(negedge clk); chk("mask h=10", bus.mask, 1); step();
        fe();
        wait_valid("flush", 1);
        step();

        // 4x4 block, found path
        set_thr(20, 40, 255, 0, 50, 255, 50, 255);
        block16(100, 50);
        fe();
        wait_valid("block", 65);
        chk("block cx", bus.centroid_x, 101);
        chk("block cy", bus.centroid_y, 51);
        chk("block count", bus.pixel_count, 16);
        chk("block found", bus.found, 1);
        step();

        // 15 pixels: not found, centroid holds
        for (int i = 0; i < 15; i++) pix(600 + i, 400, 25, 100, 100, 1'b0);
        fe();
        wait_valid("sparse", 1);
        chk("sparse found", bus.found, 0);
        chk("sparse count", bus.pixel_count, 15);
        chk("sparse cx hold", bus.centroid_x, 101);
        chk("sparse cy hold", bus.centroid_y, 51);
        step();

        // 16th pixel on the frame_end cycle
        for (int i = 0; i < 15; i++) pix(10, 20, 35, 255, 255, 1'b0);
        pix(10, 20, 35, 255, 255, 1'b1);
        wait_valid("edge pixel", 65);
        chk("edge found", bus.found, 1);
        chk("edge count", bus.pixel_count, 16);
        chk("edge cx", bus.centroid_x, 10);
        chk("edge cy", bus.centroid_y, 20);
        step();

        // Overrun during division
        block16(500, 300);
        fe();
        for (int i = 0; i < 9; i++) pix(900, 700, 30, 200, 200, 1'b0);
        bus.frame_end = 1'b1;
        @(negedge clk);
        chk("overrun pulse", bus.overrun, 1);
        step();
        bus.frame_end = 1'b0;
        wait_valid("overrun first", 55);
        chk("overrun cx", bus.centroid_x, 501);
        chk("overrun cy", bus.centroid_y, 301);
        step();
        for (int i = 0; i < 15; i++) pix(40, 40, 30, 200, 200, 1'b0);
        fe();
        wait_valid("after overrun", 1);
        chk("after overrun count", bus.pixel_count, 15);
        step();

        // Reset mid-division
        block16(200, 100);
        fe();
        repeat (19) step();
        reset = 1'b0;
        @(negedge clk);
        chk("rst busy", bus.busy, 0);
        chk("rst count", bus.pixel_count, 0);
        chk("rst cx", bus.centroid_x, 0);
        chk("rst found", bus.found, 0);
        step(); step();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.centroid_valid) seen++;
        end
        chk("no valid after reset", seen, 0);
        step();
        block16(300, 200);
        fe();
        wait_valid("post reset", 65);
        chk("post reset cx", bus.centroid_x, 301);
        chk("post reset cy", bus.centroid_y, 201);
        step();

        // Randomized frames against the model
        for (int f = 0; f < 30; f++) begin
            int a, b, npix, gap;
            a = $urandom_range(0, 100); b = a + $urandom_range(0, 120);
            if ($urandom_range(0, 5) == 0) set_thr(b, a, 200, 230, 0, 255, 0, 255);
            else set_thr(a, b, $urandom_range(150, 255), $urandom_range(150, 255),
                         $urandom_range(0, 100), 255, $urandom_range(0, 100), 255);
            npix = $urandom_range(10, 90);
            for (int i = 0; i < npix; i++) begin
                bus.enable = ($urandom_range(0, 7) != 0);
                bus.pixel_valid = ($urandom_range(0, 3) != 0);
                bus.hcount = 11'($urandom_range(0, 1023));
                bus.vcount = 10'($urandom_range(0, 767));
                bus.h = 8'($urandom); bus.s = 8'($urandom); bus.v = 8'($urandom);
                bus.frame_end = (i == npix - 1) && ($urandom_range(0, 1) == 1);
                step();
            end
            bus.pixel_valid = 1'b0;
            bus.enable = 1'b1;
            if (!bus.frame_end) fe();
            bus.frame_end = 1'b0;
            gap = $urandom_range(0, 80);
            repeat (gap) step();
        end
        repeat (100) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
